// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
//   Shares one single-port synchronous framebuffer RAM between the VGA
//   scan-out fetch and a buffered pixel writer, all in the VGA_CLK domain.
//   Scan-out reads always win and return with a fixed 3-cycle latency.
//   Writer pixels wait in a small FIFO and drain on cycles with no read.
//
//   Optional build macro: VGA_FB_ARB_STATS_EN
//     Adds STALL_CYCLES (saturating count of cycles where queued writes were
//     held off by a display read) and OVERRUN (sticky, a pixel was offered
//     while the FIFO was full). Both are cleared only by reset.
module vga_fb_arbiter #(
  parameter int ADDR_WIDTH  = 19,
  parameter int DATA_WIDTH  = 12,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic                         VGA_CLK,
  input  logic                         VGA_RESET_N,
  input  logic                         DISP_RD_REQ,
  input  logic [ADDR_WIDTH-1:0]        DISP_RD_ADDR,
  output logic [DATA_WIDTH-1:0]        DISP_RD_DATA,
  output logic                         DISP_RD_VALID,
  input  logic                         WR_VALID,
  output logic                         WR_READY,
  input  logic [ADDR_WIDTH-1:0]        WR_ADDR,
  input  logic [DATA_WIDTH-1:0]        WR_DATA,
  output logic [ADDR_WIDTH-1:0]        MEM_ADDR,
  output logic [DATA_WIDTH-1:0]        MEM_WDATA,
  output logic                         MEM_WE,
  input  logic [DATA_WIDTH-1:0]        MEM_RDATA,
  output logic [$clog2(WFIFO_DEPTH):0] WFIFO_COUNT
`ifdef VGA_FB_ARB_STATS_EN
  ,
  output logic [15:0]                  STALL_CYCLES,
  output logic [0:0]                   OVERRUN
`endif
);

  localparam int PTR_W = $clog2(WFIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WFIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Pointer wrap relies on natural binary overflow, so depth must be 2^n.
  if (WFIFO_DEPTH < 2 || (WFIFO_DEPTH & (WFIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("vga_fb_arbiter: WFIFO_DEPTH must be a power of two and at least 2");
  end

  // Registered grant: which requester owns the RAM port this cycle.
  typedef enum logic [1:0] {
    GRANT_IDLE  = 2'd0,
    GRANT_DISP  = 2'd1,
    GRANT_WRITE = 2'd2
  } grant_e;

  grant_e grant_q;
  grant_e grant_d;

  // ---------------------------------------------------------------------------
  // Write FIFO
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] fifo_addr_q [WFIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [WFIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;

  assign fifo_empty  = (count_q == '0);
  assign WR_READY    = (count_q != CNT_FULL);
  assign push        = WR_VALID & WR_READY;
  assign WFIFO_COUNT = count_q;

  // Registered RAM command (next values come from the grant output logic).
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d;
  logic                  mem_we_d;

  // Read return pipeline: high in the cycle MEM_RDATA carries a display pixel.
  logic rd_return_q;

  // ---------------------------------------------------------------------------
  // Grant FSM
  // ---------------------------------------------------------------------------

  // Grant state register.
  // NOTE: clocked blocks use non-blocking (<=) so every register samples
  // pre-edge values, independent of block ordering in the simulator.
  always_ff @(posedge VGA_CLK) begin
    if (!VGA_RESET_N) begin
      grant_q <= GRANT_IDLE;
    end else begin
      grant_q <= grant_d;
    end
  end

  // Next grant: display has strict priority, queued writes take any gap.
  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    grant_d = GRANT_IDLE;
    if (DISP_RD_REQ) begin
      grant_d = GRANT_DISP;
    end else if (!fifo_empty) begin
      grant_d = GRANT_WRITE;
    end
  end

  // Grant outputs: RAM command for the next cycle and the FIFO pop strobe.
  always_comb begin
    mem_addr_d  = MEM_ADDR;
    mem_wdata_d = MEM_WDATA;
    mem_we_d    = 1'b0;
    pop         = 1'b0;
    case (grant_d)
      GRANT_DISP: begin
        mem_addr_d = DISP_RD_ADDR;
      end
      GRANT_WRITE: begin
        mem_addr_d  = fifo_addr_q[rd_ptr_q];
        mem_wdata_d = fifo_data_q[rd_ptr_q];
        mem_we_d    = 1'b1;
        pop         = 1'b1;
      end
      default: begin
        // Idle: address and data hold, write enable stays low.
      end
    endcase
  end

  // RAM command registers driving the framebuffer port.
  always_ff @(posedge VGA_CLK) begin
    if (!VGA_RESET_N) begin
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      MEM_WE    <= 1'b0;
    end else begin
      MEM_ADDR  <= mem_addr_d;
      MEM_WDATA <= mem_wdata_d;
      MEM_WE    <= mem_we_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------

  // FIFO storage: written on push only.
  // NOTE: the entry array is deliberately not reset; the pointers and count
  // decide which entries are live, so stale contents are never observed.
  always_ff @(posedge VGA_CLK) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= WR_ADDR;
      fifo_data_q[wr_ptr_q] <= WR_DATA;
    end
  end

  // FIFO pointers and occupancy; reset discards every queued pixel.
  always_ff @(posedge VGA_CLK) begin
    if (!VGA_RESET_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read return path
  // ---------------------------------------------------------------------------

  // Track reads through the RAM and register the returned pixel.
  // Request at t -> grant_q=DISP at t+1 -> rd_return_q at t+2 -> valid at t+3.
  always_ff @(posedge VGA_CLK) begin
    if (!VGA_RESET_N) begin
      rd_return_q   <= 1'b0;
      DISP_RD_VALID <= 1'b0;
      DISP_RD_DATA  <= '0;
    end else begin
      rd_return_q   <= (grant_q == GRANT_DISP);
      DISP_RD_VALID <= rd_return_q;
      if (rd_return_q) begin
        DISP_RD_DATA <= MEM_RDATA;
      end
    end
  end

`ifdef VGA_FB_ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  logic [15:0] stall_q;
  logic        overrun_q;

  assign STALL_CYCLES = stall_q;
  assign OVERRUN      = overrun_q;

  // Count write stalls (saturating) and latch any push attempt while full.
  always_ff @(posedge VGA_CLK) begin
    if (!VGA_RESET_N) begin
      stall_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (DISP_RD_REQ && !fifo_empty && stall_q != 16'hFFFF) begin
        stall_q <= stall_q + 16'd1;
      end
      if (WR_VALID && !WR_READY) begin
        overrun_q <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between two requesters: the VGA scan-out fetch (strict priority, fixed latency) and a pixel writer (valid/ready, buffered).
- The scan-out side issues one read per visible pixel. Writer traffic drains into blanking gaps and any idle cycles.
- Sits between the VGA timing/driver logic and the framebuffer RAM, in the VGA_CLK domain.

Parameters:
- ADDR_WIDTH, 19, framebuffer word address width (800x600 = 480000 < 2^19).
- DATA_WIDTH, 12, pixel width ({R[3:0],G[3:0],B[3:0]}).
- WFIFO_DEPTH, 4, write FIFO entries; must be a power of two, at least 2.

Ports:
- VGA_CLK  in  1  pixel clock (40 MHz for SVGA 800x600@60).
- VGA_RESET_N  in  1  synchronous, active-low reset.
- DISP_RD_REQ  in  1  scan-out read request this cycle.
- DISP_RD_ADDR  in  ADDR_WIDTH  scan-out read address.
- DISP_RD_DATA  out  DATA_WIDTH  returned pixel, registered.
- DISP_RD_VALID  out  1  DISP_RD_DATA valid.
- WR_VALID  in  1  writer has a pixel.
- WR_READY  out  1  FIFO can accept.
- WR_ADDR  in  ADDR_WIDTH  write address.
- WR_DATA  in  DATA_WIDTH  write pixel.
- MEM_ADDR  out  ADDR_WIDTH  RAM address, registered.
- MEM_WDATA  out  DATA_WIDTH  RAM write data, registered.
- MEM_WE  out  1  RAM write enable, registered.
- MEM_RDATA  in  DATA_WIDTH  RAM read data; valid one cycle after MEM_ADDR is presented with MEM_WE=0.
- WFIFO_COUNT  out  clog2(WFIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock and reset: one clock, VGA_CLK. VGA_RESET_N is synchronous and active-low.
- Reset values (VGA_RESET_N=0 at a rising edge):
  - MEM_ADDR=0, MEM_WDATA=0, MEM_WE=0.
  - DISP_RD_DATA=0, DISP_RD_VALID=0.
  - FIFO flushed: WFIFO_COUNT=0, WR_READY=1 from the first cycle after reset.
  - Grant state = IDLE; all read-pipeline valid bits cleared.
- Reset mid-operation: in-flight reads are dropped (no DISP_RD_VALID emitted). Queued writes are discarded and never reach RAM.
- Write FIFO:
  - WR_READY = (WFIFO_COUNT != WFIFO_DEPTH). A push occurs on WR_VALID & WR_READY.
  - Push and pop in the same cycle leave the count unchanged.
  - When full, WR_READY=0 and WR_VALID is ignored. WR_ADDR/WR_DATA must be held by the writer.
  - Pointers wrap modulo WFIFO_DEPTH. Order is strictly FIFO.
- Grant FSM, evaluated every cycle; states IDLE, DISP, WRITE (registered grant):
  - DISP_RD_REQ=1 -> DISP: MEM_ADDR<=DISP_RD_ADDR, MEM_WE<=0, tag a read in the pipeline. The FIFO does not pop.
  - else FIFO non-empty -> WRITE: pop head; MEM_ADDR<=head.addr, MEM_WDATA<=head.data, MEM_WE<=1.
  - else -> IDLE: MEM_WE<=0; MEM_ADDR and MEM_WDATA hold their previous values.
  - The display is never stalled. Writes make progress only on cycles with DISP_RD_REQ=0.
- Read latency is fixed at 3 cycles:
  - Request at cycle t -> MEM_ADDR at t+1 -> MEM_RDATA at t+2 -> DISP_RD_DATA registered, DISP_RD_VALID=1 at t+3.
  - Back-to-back requests return back-to-back, in order.
- Ordering/hazards:
  - No write-to-read forwarding. A read of an address still queued in the FIFO returns RAM contents.
  - A write issued at cycle t+1 and a read of the same address issued at t+2 returns the new data (RAM write-first is not required because the accesses are in distinct cycles).
- WFIFO_COUNT width covers 0..WFIFO_DEPTH inclusive.

Optional Feature:
- Macro: VGA_FB_ARB_STATS_EN.
- Defined:
  - Adds output STALL_CYCLES [15:0]: counts cycles with FIFO non-empty and DISP_RD_REQ=1, saturating at 16'hFFFF.
  - Adds output OVERRUN [0:0]: sticky, set when WR_VALID=1 and WR_READY=0.
  - Both cleared only by reset.
- Not defined: neither port exists and there is no added logic.

Test Plan:
- Reset, then idle 10 cycles -> MEM_WE=0, DISP_RD_VALID=0, WR_READY=1, WFIFO_COUNT=0.
- 800 consecutive DISP_RD_REQ, addr 0..799, RAM preloaded addr->addr[11:0] -> DISP_RD_VALID high for exactly 800 cycles starting 3 cycles after first request; data 0..799 in order.
- Writer pushes 6 pixels (addr 1000..1005, data 12'hA00..12'hA05) while DISP_RD_REQ=1 -> WR_READY drops after 4 accepted, WFIFO_COUNT=4, MEM_WE=0. On DISP_RD_REQ=0 the 4 writes issue on consecutive cycles, then the remaining 2; RAM holds all 6.
- Interleave DISP_RD_REQ 1,0,1,0 with 2 queued writes -> MEM_WE pattern 0,1,0,1. Reads return at t+3 unaffected.
- Assert VGA_RESET_N=0 for 1 cycle with 3 writes queued and 2 reads in flight -> no further DISP_RD_VALID, no MEM_WE, WFIFO_COUNT=0 next cycle.
- With VGA_FB_ARB_STATS_EN: 20 cycles FIFO non-empty under DISP_RD_REQ=1, plus one push while full -> STALL_CYCLES=20, OVERRUN=1.
